core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TMO, default 16, max cycles waiting for mem_ack (range 2..255).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports i_req in 1, i_addr in ADDR_W: instruction-fetch request (read-only).
REQ-007 SHALL have ports i_ack out 1, i_rdata out DATA_W: fetch completion pulse and data.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W: data-access request.
REQ-009 SHALL have ports d_ack out 1, d_rdata out DATA_W: data completion pulse and read data.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W: shared memory port request.
REQ-011 SHALL have ports mem_ack in 1, mem_rdata in DATA_W: memory completion, rdata valid with ack.
REQ-012 SHALL have port err out 1: sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE with any request, SHALL select the winner, register its command, and move to BUSY next cycle.
- Arbitration: round-robin via 1-bit last_grant.
- Both requesting: grant the one not granted last.
- Single requester: grant it unconditionally.
REQ-015 In BUSY, SHALL hold mem_req=1 with stable mem_we/mem_addr/mem_wdata from the registered command; mem_we SHALL be 0 for fetch grants.
REQ-016 In BUSY with mem_ack=1, SHALL latch mem_rdata, deassert mem_req next cycle, and go to RESP.
REQ-017 In RESP, SHALL pulse the granted requester's ack for exactly one cycle with rdata valid in that cycle, update last_grant, then return to IDLE.
- Request-to-ack minimum latency: 3 cycles (IDLE sample, BUSY with immediate mem_ack, RESP).
REQ-018 Requesters SHALL hold req and command stable until their ack; the arbiter samples the command only in IDLE.
- A req deasserted mid-transaction SHALL not abort it.
REQ-019 i_rdata/d_rdata SHALL hold their last value outside ack cycles.
REQ-020 SHALL keep an 8-bit wait counter, cleared on BUSY entry and incremented each BUSY cycle without mem_ack.
- Count reaching TMO-1 without ack: go to RESP, deliver rdata=0, set err=1.
- err stays set until reset.
REQ-021 mem_ack outside BUSY SHALL be ignored.
REQ-022 RESP->IDLE costs one cycle, so back-to-back grants are separated by at least one IDLE cycle with mem_req=0.
REQ-023 i_ack and d_ack SHALL never be asserted in the same cycle.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE, last_grant=d (so fetch wins the first tie), wait counter=0, err=0, and all outputs 0, including rdata registers.
REQ-025 Reset asserted in BUSY or RESP SHALL abort the transaction with no ack issued; mem_req SHALL be 0 from the cycle after the reset edge.

Verification
REQ-026 Single fetch: i_req=1, i_addr=0x100, mem_ack on first BUSY cycle with rdata=0xDEADBEEF -> i_ack=1 in cycle 3 with i_rdata=0xDEADBEEF; d_ack stays 0.
REQ-027 Simultaneous i_req and d_req held from reset release -> grant order fetch, data, fetch, data; mem_addr alternates accordingly; no double acks.
REQ-028 Data write d_we=1, d_addr=0x40, d_wdata=0x12345678, mem_ack delayed 5 cycles -> mem_req high for 6 cycles with stable fields and mem_we=1, then d_ack pulse.
REQ-029 mem_ack never asserted with TMO=16 -> ack after 16 BUSY cycles with rdata=0 and err=1; err stays 1 through later successful transactions.
REQ-030 rst=0 driven in the 2nd BUSY cycle -> no ack, next cycle mem_req=0 and err=0; a following fetch completes normally.
REQ-031 Spurious mem_ack in IDLE with no requests -> no state change, no acks.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Latency: 3 cycles minimum request to ack; requesters wait in req; memory stalls via mem_ack, bounded by TMO.
module core_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t     state, state_nxt;
    cmd_t       cmd;
    logic       grant;       // 0 = fetch, 1 = data
    logic       last_grant;
    logic       pick;
    logic       tmo_hit;
    logic [7:0] wait_cnt;

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        pick = d_req;
        if (i_req && d_req) begin
            pick = ~last_grant;
        end
    end

    assign tmo_hit = (state == BUSY) && !mem_ack && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = BUSY;
            BUSY:    if (mem_ack || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == BUSY);
        i_ack   = (state == RESP) && !grant;
        d_ack   = (state == RESP) && grant;
    end

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            err        <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant    <= pick;
                        wait_cnt <= 8'd0;
                        if (pick) begin
                            cmd <= '{we: d_we, addr: d_addr, wdata: d_wdata};
                        end else begin
                            cmd <= '{we: 1'b0, addr: i_addr, wdata: '0};
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack || tmo_hit) begin
                        // A timed-out access returns zero data and latches the sticky error.
                        if (grant) begin
                            d_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            i_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        if (!mem_ack) begin
                            err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized bench: transaction-level model of round-robin grants, memory latency and timeouts.
module tb_core_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int STARVE_LIM = 2 * TMO + 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_req, mem_we, err;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    bit          m_last, m_err;
    bit          ip, dp, dwe_m;
    logic [31:0] ia, da, dwd, i_hold, d_hold, exp_rdata;
    bit          in_txn, exp_grant, resp_due, after_resp, inj_rst, rst_chk;
    int          busy_cnt, delay, wait_i, wait_d;

    initial begin
        rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_acks", {i_ack, d_ack}, 0);
        check_eq("rst_mem_fields", {mem_we, mem_addr, mem_wdata}, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rdata", {i_rdata, d_rdata}, 0);

        // Single fetch with immediate memory ack
        rst = 1'b1; i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        check_eq("f1_mem_req", mem_req, 1);
        check_eq("f1_mem_addr", mem_addr, 32'h100);
        check_eq("f1_mem_we", mem_we, 0);
        check_eq("f1_early_ack", i_ack, 0);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("f1_i_ack", i_ack, 1);
        check_eq("f1_i_rdata", i_rdata, 32'hDEADBEEF);
        check_eq("f1_d_ack", d_ack, 0);
        check_eq("f1_mem_req_off", mem_req, 0);
        i_req = 0; mem_ack = 0;
        @(negedge clk);
        check_eq("f1_ack_once", i_ack, 0);

        // Spurious memory acks while idle with no requesters
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        repeat (3) begin
            @(negedge clk);
            check_eq("spur_mem_req", mem_req, 0);
            check_eq("spur_acks", {i_ack, d_ack}, 0);
            check_eq("spur_i_rdata", i_rdata, 32'hDEADBEEF);
        end
        mem_ack = 0;

        m_last = 0; m_err = 0; ip = 0; dp = 0; in_txn = 0; resp_due = 0;
        after_resp = 0; inj_rst = 0; rst_chk = 0; wait_i = 0; wait_d = 0;
        i_hold = 32'hDEADBEEF; d_hold = '0; exp_grant = 0; busy_cnt = 0; delay = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (rst_chk) begin
                check_eq("rst_abort_mem_req", mem_req, 0);
                check_eq("rst_abort_acks", {i_ack, d_ack}, 0);
                check_eq("rst_abort_err", err, 0);
                check_eq("rst_abort_rdata", {i_rdata, d_rdata}, 0);
                rst = 1; rst_chk = 0;
                m_last = 1; m_err = 0; i_hold = '0; d_hold = '0;
                in_txn = 0; resp_due = 0; after_resp = 0;
                ip = 0; dp = 0; i_req = 0; d_req = 0; mem_ack = 0;
                wait_i = 0; wait_d = 0;
                continue;
            end

            check_eq("err", err, m_err);
            if (after_resp) begin
                check_eq("idle_gap", mem_req, 0);
                after_resp = 0;
            end

            if (resp_due) begin
                check_eq("resp_mem_req", mem_req, 0);
                check_eq("resp_i_ack", i_ack, !exp_grant);
                check_eq("resp_d_ack", d_ack, exp_grant);
                if (exp_grant) begin
                    d_hold = exp_rdata;
                    d_req = 0; dp = 0; wait_d = 0;
                end else begin
                    i_hold = exp_rdata;
                    i_req = 0; ip = 0; wait_i = 0;
                end
                check_eq("resp_i_rdata", i_rdata, i_hold);
                check_eq("resp_d_rdata", d_rdata, d_hold);
                m_last = exp_grant;
                resp_due = 0; after_resp = 1; in_txn = 0;
                mem_ack = $urandom_range(0, 1) == 0;
                mem_rdata = $urandom;
            end else if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1; busy_cnt = 0;
                    check_eq("grant_has_req", ip || dp, 1);
                    exp_grant = (ip && dp) ? ~m_last : dp;
                    delay = ($urandom_range(0, 7) == 0) ? TMO + 5 : $urandom_range(0, 6);
                    inj_rst = ($urandom_range(0, 15) == 0) && (delay >= 2);
                end
                check_eq("mem_addr", mem_addr, exp_grant ? da : ia);
                check_eq("mem_we", mem_we, exp_grant ? dwe_m : 1'b0);
                if (exp_grant) check_eq("mem_wdata", mem_wdata, dwd);
                check_eq("busy_acks", {i_ack, d_ack}, 0);
                check_eq("busy_len_ok", busy_cnt < TMO, 1);
                check_eq("rdata_hold", {i_rdata, d_rdata}, {i_hold, d_hold});
                if (inj_rst && busy_cnt == 1) begin
                    rst = 0; mem_ack = 0; rst_chk = 1;
                end else if (busy_cnt == delay) begin
                    mem_ack = 1; mem_rdata = $urandom;
                    exp_rdata = mem_rdata; resp_due = 1;
                end else begin
                    mem_ack = 0; mem_rdata = $urandom;
                    if (busy_cnt == TMO - 1) begin
                        resp_due = 1; exp_rdata = '0; m_err = 1;
                    end
                end
                busy_cnt++;
            end else begin
                check_eq("mem_req_dropped_early", in_txn, 0);
                check_eq("idle_acks", {i_ack, d_ack}, 0);
                check_eq("idle_rdata_hold", {i_rdata, d_rdata}, {i_hold, d_hold});
                mem_ack = $urandom_range(0, 3) == 0;
                mem_rdata = $urandom;
            end

            if (rst_chk) continue;
            if (ip) wait_i++;
            if (dp) wait_d++;
            check_eq("fetch_starved", wait_i > STARVE_LIM, 0);
            check_eq("data_starved", wait_d > STARVE_LIM, 0);
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; i_req = 1; i_addr = $urandom; ia = i_addr;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; d_req = 1; d_addr = $urandom; d_wdata = $urandom;
                d_we = $urandom_range(0, 1); da = d_addr; dwd = d_wdata; dwe_m = d_we;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
